// File: rtl/bt_uart_digit_rx_if.sv
// Serial line and decoded-digit outputs of the Bluetooth UART receiver.
// slave is the receiver's view; master is the view of whoever drives rx and consumes results.
interface bt_uart_digit_rx_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_error;
  logic [3:0] digit;
  logic       digit_valid;

  modport slave (
    input  rx,
    output rx_data, rx_valid, frame_error, digit, digit_valid
  );

  modport master (
    output rx,
    input  rx_data, rx_valid, frame_error, digit, digit_valid
  );
endinterface

// File: rtl/bt_uart_digit_rx.sv
// 8N1 UART receiver that turns ASCII hex characters into a held 4-bit digit
// for the seven-segment stage. The serial input is synchronised before use.
module bt_uart_digit_rx #(
  parameter int CLK_FREQ = 27_000_000,
  parameter int BAUD     = 9600
) (
  input  logic              clock,
  input  logic              reset_n,
  bt_uart_digit_rx_if.slave bus
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t        state_q, state_d;
  logic [1:0]    rxSync_q;
  logic [CW-1:0] clkCnt_q, clkCnt_d;
  logic [2:0]    bitIdx_q, bitIdx_d;
  logic [7:0]    shiftReg_q, shiftReg_d;
  logic [7:0]    rxData_q, rxData_d;
  logic          rxValid_q, rxValid_d;
  logic          frameErr_q, frameErr_d;
  logic [3:0]    digit_q, digit_d;
  logic          digitValid_q, digitValid_d;
  logic          rxS;
  logic [4:0]    hex;

  // Returns {is_hex, value}; 'A'-'F' and 'a'-'f' both carry 1..6 in the low nibble.
  function automatic logic [4:0] decodeHex(input logic [7:0] b);
    logic [4:0] r;
    r = 5'b0;
    if (b >= 8'h30 && b <= 8'h39)
      r = {1'b1, b[3:0]};
    else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66))
      r = {1'b1, b[3:0] + 4'd9};
    return r;
  endfunction

  assign rxS = rxSync_q[1];
  assign hex = decodeHex(shiftReg_q);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rxSync_q     <= 2'b11;
      state_q      <= S_IDLE;
      clkCnt_q     <= '0;
      bitIdx_q     <= '0;
      shiftReg_q   <= '0;
      rxData_q     <= '0;
      rxValid_q    <= 1'b0;
      frameErr_q   <= 1'b0;
      digit_q      <= '0;
      digitValid_q <= 1'b0;
    end else begin
      rxSync_q     <= {rxSync_q[0], bus.rx};
      state_q      <= state_d;
      clkCnt_q     <= clkCnt_d;
      bitIdx_q     <= bitIdx_d;
      shiftReg_q   <= shiftReg_d;
      rxData_q     <= rxData_d;
      rxValid_q    <= rxValid_d;
      frameErr_q   <= frameErr_d;
      digit_q      <= digit_d;
      digitValid_q <= digitValid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    clkCnt_d     = clkCnt_q;
    bitIdx_d     = bitIdx_q;
    shiftReg_d   = shiftReg_q;
    rxData_d     = rxData_q;
    rxValid_d    = 1'b0;
    frameErr_d   = 1'b0;
    digit_d      = digit_q;
    digitValid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rxS) begin
          state_d  = S_START;
          clkCnt_d = '0;
        end
      end
      S_START: begin
        if (clkCnt_q == HALF_LAST) begin
          clkCnt_d = '0;
          if (!rxS) begin
            state_d  = S_DATA;
            bitIdx_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          clkCnt_d = clkCnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (clkCnt_q == BIT_LAST) begin
          clkCnt_d             = '0;
          shiftReg_d[bitIdx_q] = rxS;
          if (bitIdx_q == 3'd7)
            state_d = S_STOP;
          else
            bitIdx_d = bitIdx_q + 3'd1;
        end else begin
          clkCnt_d = clkCnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (clkCnt_q == BIT_LAST) begin
          clkCnt_d = '0;
          if (rxS) begin
            state_d   = S_IDLE;
            rxData_d  = shiftReg_q;
            rxValid_d = 1'b1;
            if (hex[4]) begin
              digit_d      = hex[3:0];
              digitValid_d = 1'b1;
            end
          end else begin
            state_d    = S_BREAK;
            frameErr_d = 1'b1;
          end
        end else begin
          clkCnt_d = clkCnt_q + CW'(1);
        end
      end
      // A line held low after a bad stop bit must not start new frames.
      S_BREAK: begin
        if (rxS) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.rx_data     = rxData_q;
  assign bus.rx_valid    = rxValid_q;
  assign bus.frame_error = frameErr_q;
  assign bus.digit       = digit_q;
  assign bus.digit_valid = digitValid_q;
endmodule
